// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/response bundle between the ALU/MEM requesters and the
// register-unit write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic                    alu_valid;
  logic                    alu_ready;
  logic [REGW-1:0]         alu_rd;
  logic [XLEN-1:0]         alu_data;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [REGW-1:0]         mem_rd;
  logic [XLEN-1:0]         mem_data;
  logic [REGW-1:0]         rd;
  logic [XLEN-1:0]         DataWr;
  logic                    RuWr;
  logic [(1 << REGW)-1:0]  pending;
  logic                    idle;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rd, DataWr, RuWr, pending, idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rd, DataWr, RuWr, pending, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-unit write port between ALU and MEM writeback
// FIFOs with round-robin arbitration and a per-register pending scoreboard.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int REGW  = 5
) (
  input logic               CLK,
  input logic               RST,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int NREG = 1 << REGW;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

  src_t prio_q, prio_d, gnt;
  logic gidx;

  logic [REGW-1:0] q_rd   [2][DEPTH];
  logic [XLEN-1:0] q_data [2][DEPTH];
  logic [PW-1:0]   wptr   [2];
  logic [PW-1:0]   rptr   [2];
  logic [CW-1:0]   cnt    [2];

  logic            in_valid [2];
  logic [REGW-1:0] in_rd    [2];
  logic [XLEN-1:0] in_data  [2];

  logic [1:0] head_v, ready, push, pop;
  logic       ruwr;
  logic [NREG-1:0] pend;
  logic [PW-1:0]   idx;

  assign in_valid[0] = bus.alu_valid;
  assign in_rd[0]    = bus.alu_rd;
  assign in_data[0]  = bus.alu_data;
  assign in_valid[1] = bus.mem_valid;
  assign in_rd[1]    = bus.mem_rd;
  assign in_data[1]  = bus.mem_data;

  // A full FIFO refuses input even when it pops in the same cycle.
  always_comb begin
    head_v = '0;
    ready  = '0;
    push   = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      head_v[s] = (cnt[s] != '0);
      ready[s]  = !RST && (cnt[s] != CW'(DEPTH));
      push[s]   = in_valid[s] && ready[s] && (in_rd[s] != '0);
    end
  end

  always_comb begin
    gnt = SRC_ALU;
    if (head_v[0] && head_v[1])
      gnt = prio_q;
    else if (head_v[1])
      gnt = SRC_MEM;
    gidx = (gnt == SRC_MEM);
    ruwr = !RST && (head_v != '0);
    pop  = '0;
    if (ruwr)
      pop[gidx] = 1'b1;
    prio_d = prio_q;
    if (!RST && (head_v == 2'b11))
      prio_d = (prio_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end

  always_comb begin
    pend = '0;
    idx  = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rptr[s] + PW'(i);
        if (CW'(i) < cnt[s])
          pend[q_rd[s][idx]] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q <= SRC_ALU;
      for (int unsigned s = 0; s < 2; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
        cnt[s]  <= '0;
      end
    end else begin
      prio_q <= prio_d;
      for (int unsigned s = 0; s < 2; s++) begin
        if (push[s])
          wptr[s] <= wptr[s] + 1'b1;
        if (pop[s])
          rptr[s] <= rptr[s] + 1'b1;
        cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
      end
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and counts.
  always_ff @(posedge CLK) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (push[s]) begin
        q_rd[s][wptr[s]]   <= in_rd[s];
        q_data[s][wptr[s]] <= in_data[s];
      end
    end
  end

  assign bus.alu_ready = ready[0];
  assign bus.mem_ready = ready[1];
  assign bus.RuWr      = ruwr;
  assign bus.rd        = ruwr ? q_rd[gidx][rptr[gidx]]   : '0;
  assign bus.DataWr    = ruwr ? q_data[gidx][rptr[gidx]] : '0;
  assign bus.pending   = pend;
  assign bus.idle      = (cnt[0] == '0) && (cnt[1] == '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, saturation sequence
// and randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int REGW  = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .REGW(REGW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        ea;
    logic        em;
    logic        er;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic [31:0] ep;
    logic        ei;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ent_t aq[$];
  ent_t mq[$];
  bit   prio_mem = 1'b0;

  logic s_ruwr, s_ar, s_mr;

  function automatic vec_t mkv(logic rst, logic av, logic [4:0] ard, logic [31:0] ad,
                               logic mv, logic [4:0] mrd, logic [31:0] md,
                               logic ea, logic em, logic er, logic [4:0] erd,
                               logic [31:0] ed, logic [31:0] ep, logic ei);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.ea = ea; v.em = em; v.er = er; v.erd = erd; v.ed = ed; v.ep = ep; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_eval(input logic rst, output logic ea, output logic em,
                            output logic er, output logic [4:0] erd,
                            output logic [31:0] ed, output logic [31:0] ep,
                            output logic ei, output bit gm);
    bit ha, hm;
    ha  = (aq.size() != 0);
    hm  = (mq.size() != 0);
    ea  = !rst && (aq.size() < DEPTH);
    em  = !rst && (mq.size() < DEPTH);
    er  = !rst && (ha || hm);
    gm  = (ha && hm) ? prio_mem : hm;
    erd = '0;
    ed  = '0;
    if (er) begin
      erd = gm ? mq[0].rd   : aq[0].rd;
      ed  = gm ? mq[0].data : aq[0].data;
    end
    ep = '0;
    foreach (aq[i]) ep[aq[i].rd] = 1'b1;
    foreach (mq[i]) ep[mq[i].rd] = 1'b1;
    ei = !ha && !hm;
  endtask

  task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag,
                           output bit acc_a, output bit acc_m);
    logic m_ea, m_em, m_er, m_ei, x_ea, x_em, x_er, x_ei;
    logic [4:0] m_erd, x_erd;
    logic [31:0] m_ed, m_ep, x_ed, x_ep;
    bit gm, contended;
    RST           = v.rst;
    bus.alu_valid = v.av;
    bus.alu_rd    = v.ard;
    bus.alu_data  = v.ad;
    bus.mem_valid = v.mv;
    bus.mem_rd    = v.mrd;
    bus.mem_data  = v.md;
    @(negedge CLK);
    model_eval(v.rst, m_ea, m_em, m_er, m_erd, m_ed, m_ep, m_ei, gm);
    if (use_tbl) begin
      x_ea = v.ea; x_em = v.em; x_er = v.er; x_erd = v.erd;
      x_ed = v.ed; x_ep = v.ep; x_ei = v.ei;
    end else begin
      x_ea = m_ea; x_em = m_em; x_er = m_er; x_erd = m_erd;
      x_ed = m_ed; x_ep = m_ep; x_ei = m_ei;
    end
    chk({tag, "alu_ready"}, 32'(bus.alu_ready), 32'(x_ea));
    chk({tag, "mem_ready"}, 32'(bus.mem_ready), 32'(x_em));
    chk({tag, "RuWr"},      32'(bus.RuWr),      32'(x_er));
    chk({tag, "rd"},        32'(bus.rd),        32'(x_erd));
    chk({tag, "DataWr"},    bus.DataWr,         x_ed);
    chk({tag, "pending"},   bus.pending,        x_ep);
    chk({tag, "idle"},      32'(bus.idle),      32'(x_ei));
    s_ruwr = bus.RuWr;
    s_ar   = bus.alu_ready;
    s_mr   = bus.mem_ready;
    acc_a  = v.av && m_ea;
    acc_m  = v.mv && m_em;
    contended = (aq.size() != 0) && (mq.size() != 0);
    @(posedge CLK);
    if (v.rst) begin
      aq.delete();
      mq.delete();
      prio_mem = 1'b0;
    end else begin
      if (m_er) begin
        if (gm) void'(mq.pop_front());
        else    void'(aq.pop_front());
      end
      if (contended) prio_mem = !prio_mem;
      if (acc_a && v.ard != 5'd0) aq.push_back('{rd: v.ard, data: v.ad});
      if (acc_m && v.mrd != 5'd0) mq.push_back('{rd: v.mrd, data: v.md});
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    vec_t v;
    bit aa, am, hold_a, hold_m, a_drop, m_drop;
    int unsigned a_idx, m_idx, ruwr_cnt;

    //           rst   av    ard     ad            mv    mrd     md            ea    em    er    erd     ed            ep            ei
    tbl[0]  = mkv(1'b1, 1'b1, 5'd7,  32'h1,        1'b1, 5'd8,  32'h2,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[1]  = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[2]  = mkv(1'b0, 1'b1, 5'd18, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[3]  = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd18, 32'hDEADBEEF, 32'h00040000, 1'b0);
    tbl[4]  = mkv(1'b0, 1'b1, 5'd5,  32'h11,       1'b1, 5'd6,  32'h22,       1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[5]  = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd5,  32'h11,       32'h60,       1'b0);
    tbl[6]  = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd6,  32'h22,       32'h40,       1'b0);
    tbl[7]  = mkv(1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[8]  = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[9]  = mkv(1'b0, 1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44,       1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[10] = mkv(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h18,       1'b0);
    tbl[11] = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[12] = mkv(1'b0, 1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,       1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);
    tbl[13] = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd9,  32'h99,       32'h600,      1'b0);
    tbl[14] = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd10, 32'hAA,       32'h400,      1'b0);
    tbl[15] = mkv(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1);

    // Unchecked first reset cycle: state is unknown before the first edge.
    RST           = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'h1;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd8;
    bus.mem_data  = 32'h2;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 16; i++)
      run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d_", i), aa, am);

    // Saturation: both sources push every cycle from an empty, freshly reset state.
    v = mkv(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    run_cycle(v, 1'b0, "sat_rst_", aa, am);
    a_idx = 0; m_idx = 0; ruwr_cnt = 0; a_drop = 1'b0; m_drop = 1'b0;
    for (int c = 0; c < 10; c++) begin
      v.rst = 1'b0;
      v.av  = 1'b1;
      v.ard = 5'(1 + a_idx);
      v.ad  = 32'hA000_0000 + a_idx;
      v.mv  = 1'b1;
      v.mrd = 5'(16 + m_idx);
      v.md  = 32'hB000_0000 + m_idx;
      run_cycle(v, 1'b0, "sat_", aa, am);
      if (aa) a_idx++;
      if (am) m_idx++;
      if (s_ruwr === 1'b1) ruwr_cnt++;
      if (s_ar === 1'b0) a_drop = 1'b1;
      if (s_mr === 1'b0) m_drop = 1'b1;
    end
    chk("sat_ruwr_cycles", ruwr_cnt, 32'd9);
    chk("sat_alu_ready_dropped", 32'(a_drop), 32'd1);
    chk("sat_mem_ready_dropped", 32'(m_drop), 32'd1);

    // Randomized traffic with occasional reset; requests held while not accepted.
    hold_a = 1'b0;
    hold_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v.rst = ($urandom_range(0, 49) == 0);
      if (!hold_a) begin
        v.av  = ($urandom_range(0, 9) < 7);
        v.ard = 5'($urandom_range(0, 31));
        v.ad  = $urandom;
      end
      if (!hold_m) begin
        v.mv  = ($urandom_range(0, 9) < 7);
        v.mrd = 5'($urandom_range(0, 31));
        v.md  = $urandom;
      end
      run_cycle(v, 1'b0, "rnd_", aa, am);
      hold_a = v.av && !aa;
      hold_m = v.mv && !am;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
